// File: rtl/rr_stream_arbiter.sv
// Round-robin merge of N_REQ valid/ready byte streams onto one registered output channel.
// A requester keeps the grant for up to MAX_BURST consecutive beats; each beat carries its source index.
module rr_stream_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WORD_WIDTH = 8,
  parameter int MAX_BURST  = 2,
  localparam int SRC_W     = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              up_valid,
  input  logic [N_REQ*WORD_WIDTH-1:0]   up_data,
  output logic [N_REQ-1:0]              up_ready,
  input  logic                          down_ready,
  output logic                          down_valid,
  output logic [WORD_WIDTH-1:0]         down_data,
  output logic [SRC_W-1:0]              down_src
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] BURST_FIRST = (MAX_BURST == 1) ? '0 : CNT_W'(1);
  localparam logic [SRC_W-1:0] OWNER_RST   = SRC_W'(N_REQ - 1);

  logic                  downValid_q, downValid_d;
  logic [WORD_WIDTH-1:0] downData_q, downData_d;
  logic [SRC_W-1:0]      downSrc_q, downSrc_d;
  logic [SRC_W-1:0]      owner_q, owner_d;
  logic [CNT_W-1:0]      burstCnt_q, burstCnt_d;

  logic             load;
  logic             anyValid;
  logic             lock;
  logic [SRC_W-1:0] sel;
  logic [SRC_W-1:0] cand;
  logic             found;

  assign load     = ~downValid_q | down_ready;
  assign anyValid = |up_valid;
  assign lock     = (burstCnt_q != '0) & up_valid[owner_q];

  // Search starts just after the owner and wraps, so the owner is considered last.
  always_comb begin
    sel   = owner_q;
    cand  = owner_q;
    found = 1'b0;
    if (!lock) begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = SRC_W'((int'(owner_q) + k) % N_REQ);
        if (!found && up_valid[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    up_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      up_ready[i] = load & anyValid & (sel == SRC_W'(i));
    end
  end

  always_comb begin
    downValid_d = downValid_q;
    downData_d  = downData_q;
    downSrc_d   = downSrc_q;
    owner_d     = owner_q;
    burstCnt_d  = burstCnt_q;
    if (load) begin
      if (anyValid) begin
        downValid_d = 1'b1;
        downData_d  = up_data[int'(sel)*WORD_WIDTH +: WORD_WIDTH];
        downSrc_d   = sel;
        owner_d     = sel;
        if (lock) begin
          burstCnt_d = (burstCnt_q == BURST_LAST) ? '0 : burstCnt_q + CNT_W'(1);
        end else begin
          burstCnt_d = BURST_FIRST;
        end
      end else begin
        // An idle cycle ends the current tenure but leaves the rotation point alone.
        downValid_d = 1'b0;
        burstCnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      downValid_q <= 1'b0;
      downData_q  <= '0;
      downSrc_q   <= '0;
      owner_q     <= OWNER_RST;
      burstCnt_q  <= '0;
    end else begin
      downValid_q <= downValid_d;
      downData_q  <= downData_d;
      downSrc_q   <= downSrc_d;
      owner_q     <= owner_d;
      burstCnt_q  <= burstCnt_d;
    end
  end

  assign down_valid = downValid_q;
  assign down_data  = downData_q;
  assign down_src   = downSrc_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter (N_REQ=4, WORD_WIDTH=8, MAX_BURST=2).
// Ends with a pseudo-random traffic phase checked by per-source sequence numbers.
module tb_rr_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  upValid;
  logic [31:0] upData;
  logic [3:0]  upReady;
  logic        downReady;
  logic        downValid;
  logic [7:0]  downData;
  logic [1:0]  downSrc;

  int testsRun  = 0;
  int failCount = 0;
  int sendSeq[4];
  int recvSeq[4];
  int upCount   = 0;
  int downCount = 0;

  always #5 clk = ~clk;

  rr_stream_arbiter #(
    .N_REQ      (4),
    .WORD_WIDTH (8),
    .MAX_BURST  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (upValid),
    .up_data    (upData),
    .up_ready   (upReady),
    .down_ready (downReady),
    .down_valid (downValid),
    .down_data  (downData),
    .down_src   (downSrc)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic dr);
    upValid   = v;
    downReady = dr;
  endtask

  task automatic setWord(input int i, input logic [7:0] w);
    upData[i*8 +: 8] = w;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Samples the pre-edge handshakes, scores any downstream consumption, then steps one clock.
  task automatic monitorCycle();
    #1;
    checkOutput("oneReady", 32'($countones(upReady) <= 1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (upValid[i] && upReady[i]) begin
        sendSeq[i]++;
        upCount++;
      end
    end
    if (downValid && downReady) begin
      checkOutput("order", 32'(downData), 32'((int'(downSrc) << 6) | (recvSeq[downSrc] & 63)));
      recvSeq[downSrc]++;
      downCount++;
    end
    nextCycle();
  endtask

  initial begin
    int seq1[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    rst = 1'b1;
    upData = '0;
    applyStimulus(4'b0000, 1'b0);
    #3;
    checkOutput("rstValid", 32'(downValid), 32'd0);
    checkOutput("rstData", 32'(downData), 32'd0);
    checkOutput("rstSrc", 32'(downSrc), 32'd0);
    nextCycle();
    rst = 1'b0;

    // All requesters busy: pairs of beats per source in rotation.
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) setWord(i, 8'(i*16 + k));
      #1;
      checkOutput("t1Ready", 32'(upReady), 32'(1) << seq1[k]);
      nextCycle();
      checkOutput("t1Valid", 32'(downValid), 32'd1);
      checkOutput("t1Src", 32'(downSrc), 32'(seq1[k]));
      checkOutput("t1Data", 32'(downData), 32'(seq1[k]*16 + k));
    end

    // Single active requester keeps the channel full across burst wraps.
    applyStimulus(4'b0100, 1'b1);
    for (int k = 0; k < 6; k++) begin
      setWord(2, 8'(8'h50 + k));
      #1;
      checkOutput("t2Ready", 32'(upReady), 32'h4);
      nextCycle();
      checkOutput("t2Valid", 32'(downValid), 32'd1);
      checkOutput("t2Src", 32'(downSrc), 32'd2);
      checkOutput("t2Data", 32'(downData), 32'h55 - 32'(5 - k));
    end

    // Stall for three cycles, then release.
    applyStimulus(4'b0100, 1'b0);
    setWord(2, 8'hEE);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("t3StallReady", 32'(upReady), 32'h0);
      nextCycle();
      checkOutput("t3StallValid", 32'(downValid), 32'd1);
      checkOutput("t3StallSrc", 32'(downSrc), 32'd2);
      checkOutput("t3StallData", 32'(downData), 32'h55);
    end
    applyStimulus(4'b0100, 1'b1);
    setWord(2, 8'h77);
    #1;
    checkOutput("t3RelReady", 32'(upReady), 32'h4);
    nextCycle();
    checkOutput("t3RelData", 32'(downData), 32'h77);
    checkOutput("t3RelSrc", 32'(downSrc), 32'd2);

    // Bubble, then requester 0 drops valid mid-burst.
    applyStimulus(4'b0000, 1'b1);
    #1;
    checkOutput("t4BubReady", 32'(upReady), 32'h0);
    nextCycle();
    checkOutput("t4BubValid", 32'(downValid), 32'd0);
    applyStimulus(4'b0001, 1'b1);
    setWord(0, 8'hA1);
    #1;
    checkOutput("t4Ready0", 32'(upReady), 32'h1);
    nextCycle();
    checkOutput("t4Data0", 32'(downData), 32'hA1);
    applyStimulus(4'b0010, 1'b1);
    setWord(1, 8'hB1);
    #1;
    checkOutput("t4Ready1", 32'(upReady), 32'h2);
    nextCycle();
    checkOutput("t4Src1", 32'(downSrc), 32'd1);
    checkOutput("t4Data1", 32'(downData), 32'hB1);
    applyStimulus(4'b0011, 1'b1);
    setWord(0, 8'hA2);
    setWord(1, 8'hB2);
    #1;
    checkOutput("t4LockReady", 32'(upReady), 32'h2);
    nextCycle();
    checkOutput("t4LockData", 32'(downData), 32'hB2);
    setWord(0, 8'hA3);
    setWord(1, 8'hB3);
    #1;
    checkOutput("t4RotReady", 32'(upReady), 32'h1);
    nextCycle();
    checkOutput("t4RotData", 32'(downData), 32'hA3);

    // Asynchronous reset while a beat is held.
    applyStimulus(4'b1111, 1'b1);
    checkOutput("t5PreValid", 32'(downValid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5RstValid", 32'(downValid), 32'd0);
    checkOutput("t5RstData", 32'(downData), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) setWord(i, 8'(8'hC0 + i));
    #1;
    checkOutput("t5Ready", 32'(upReady), 32'h1);
    nextCycle();
    checkOutput("t5Src", 32'(downSrc), 32'd0);
    checkOutput("t5Data", 32'(downData), 32'hC0);

    // Flush the held beat, then mixed traffic with down_ready toggling every 20 ns.
    applyStimulus(4'b0000, 1'b1);
    nextCycle();
    checkOutput("t6Flush", 32'(downValid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      sendSeq[i] = 0;
      recvSeq[i] = 0;
    end
    for (int cyc = 0; cyc < 200; cyc++) begin
      applyStimulus(4'($urandom_range(0, 15)), ((cyc / 2) % 2) == 0);
      for (int i = 0; i < 4; i++) setWord(i, 8'((i << 6) | (sendSeq[i] & 63)));
      monitorCycle();
    end
    applyStimulus(4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) monitorCycle();
    checkOutput("t6Count", 32'(downCount), 32'(upCount));
    checkOutput("t6Idle", 32'(downValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
